// File: rtl/ram_readback_if.sv
// Bus bundle for the RAM dump engine: start request, RAM read port,
// UART line and status outputs.
interface ram_readback_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 10
);
  logic              i_start;
  logic [DATA_W-1:0] i_ram_q;
  logic [ADDR_W-1:0] o_ram_addr;
  logic              o_ram_rden;
  logic              o_tx;
  logic              o_busy;
  logic              o_done;

  // dump engine side
  modport slave (
    input  i_start, i_ram_q,
    output o_ram_addr, o_ram_rden, o_tx, o_busy, o_done
  );

  // host / RAM side
  modport master (
    output i_start, i_ram_q,
    input  o_ram_addr, o_ram_rden, o_tx, o_busy, o_done
  );
endinterface

// File: rtl/ram_readback.sv
// Dumps a fixed RAM address window over a UART line (8N1, LSB first):
// 0xA5 header, each word as little-endian bytes, then an XOR checksum
// of the data bytes.
module ram_readback #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(16'hFC00),
  parameter int unsigned       COUNT        = 1024,
  parameter int                CLKS_PER_BIT = 434
) (
  input  logic          i_clk,
  input  logic          i_ar,
  ram_readback_if.slave bus
);

  localparam int NB    = (DATA_W + 7) / 8;
  localparam int BUF_W = NB * 8;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0]  LAST_CLK  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(COUNT - 1);
  localparam logic [2:0]        LAST_BYTE = 3'(NB - 1);
  localparam logic [7:0]        HEADER    = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_READ, S_LATCH, S_DATA, S_SUM, S_DONE
  } state_t;

  state_t state, state_next;

  // byte transmitter
  logic             tx_active;
  logic [9:0]       tx_frame;
  logic [3:0]       tx_bit;
  logic [CNT_W-1:0] tx_clk;
  logic             tx_done;

  // load request from the control FSM into the transmitter
  logic       load;
  logic       load_data;
  logic [7:0] load_byte;

  // word datapath
  logic [7:0]        checksum;
  logic [BUF_W-1:0]  word_buf;
  logic [BUF_W-1:0]  ram_ext;
  logic [BUF_W-1:0]  word_shift;
  logic [2:0]        byte_idx;
  logic [2:0]        next_byte_idx;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] ram_addr;

  assign ram_ext       = BUF_W'(bus.i_ram_q);
  assign next_byte_idx = byte_idx + 3'd1;
  assign word_shift    = word_buf >> {next_byte_idx, 3'b000};
  assign tx_done       = tx_active && (tx_bit == 4'd9) && (tx_clk == LAST_CLK);

  assign bus.o_tx       = tx_active ? tx_frame[0] : 1'b1;
  assign bus.o_ram_addr = ram_addr;

  // State register
  always_ff @(posedge i_clk or negedge i_ar) begin
    if (!i_ar) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; each transmitted byte ends on tx_done
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (bus.i_start) state_next = S_HDR;
      S_HDR:   if (tx_done) state_next = S_READ;
      S_READ:  state_next = S_LATCH;
      S_LATCH: state_next = S_DATA;
      S_DATA:
        if (tx_done && byte_idx == LAST_BYTE)
          state_next = (word_cnt == LAST_WORD) ? S_SUM : S_READ;
      S_SUM:   if (tx_done) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs and transmitter loads; the first byte of a word comes straight
  // from the RAM data since the buffer is only written on the same edge
  always_comb begin
    bus.o_ram_rden = (state == S_READ);
    bus.o_busy     = (state != S_IDLE);
    bus.o_done     = (state == S_DONE);
    load           = 1'b0;
    load_data      = 1'b0;
    load_byte      = 8'h00;
    case (state)
      S_IDLE:
        if (bus.i_start) begin
          load      = 1'b1;
          load_byte = HEADER;
        end
      S_LATCH: begin
        load      = 1'b1;
        load_data = 1'b1;
        load_byte = ram_ext[7:0];
      end
      S_DATA:
        if (tx_done) begin
          if (byte_idx != LAST_BYTE) begin
            load      = 1'b1;
            load_data = 1'b1;
            load_byte = word_shift[7:0];
          end else if (word_cnt == LAST_WORD) begin
            load      = 1'b1;
            load_byte = checksum;
          end
        end
      default: ;
    endcase
  end

  // 8N1 shifter: a load restarts the frame, otherwise each bit lasts CLKS_PER_BIT
  always_ff @(posedge i_clk or negedge i_ar) begin
    if (!i_ar) begin
      tx_active <= 1'b0;
      tx_frame  <= '1;
      tx_bit    <= '0;
      tx_clk    <= '0;
    end else if (load) begin
      tx_active <= 1'b1;
      tx_frame  <= {1'b1, load_byte, 1'b0};
      tx_bit    <= '0;
      tx_clk    <= '0;
    end else if (tx_active) begin
      if (tx_clk == LAST_CLK) begin
        tx_clk   <= '0;
        tx_frame <= {1'b1, tx_frame[9:1]};
        if (tx_bit == 4'd9) tx_active <= 1'b0;
        else                tx_bit    <= tx_bit + 4'd1;
      end else begin
        tx_clk <= tx_clk + CNT_W'(1);
      end
    end
  end

  // Checksum, word buffer, byte/word counters and read address
  always_ff @(posedge i_clk or negedge i_ar) begin
    if (!i_ar) begin
      checksum <= '0;
      word_buf <= '0;
      byte_idx <= '0;
      word_cnt <= '0;
      ram_addr <= BASE_ADDR;
    end else begin
      if (state == S_IDLE && bus.i_start) begin
        checksum <= '0;
        word_cnt <= '0;
      end else if (load && load_data) begin
        checksum <= checksum ^ load_byte;
      end

      if (state == S_HDR && tx_done)
        ram_addr <= BASE_ADDR;
      if (state == S_DATA && tx_done && byte_idx == LAST_BYTE && word_cnt != LAST_WORD) begin
        word_cnt <= word_cnt + ADDR_W'(1);
        ram_addr <= ram_addr + ADDR_W'(1);
      end

      if (state == S_LATCH) begin
        word_buf <= ram_ext;
        byte_idx <= '0;
      end else if (state == S_DATA && tx_done && byte_idx != LAST_BYTE) begin
        byte_idx <= next_byte_idx;
      end
    end
  end

endmodule

// File: tb/tb_ram_readback.sv
// Directed bench for ram_readback: a one-word and a three-word (address
// wrapping) instance share clock and reset; a mid-bit sampling 8N1
// receiver decodes both UART lines.
module tb_ram_readback;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic ar  = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // cycle stamp, stable when sampled on the falling edge
  always @(posedge clk) cyc <= cyc + 1;

  ram_readback_if #(.ADDR_W(16), .DATA_W(10)) bus1 ();
  ram_readback_if #(.ADDR_W(16), .DATA_W(10)) bus3 ();

  ram_readback #(.ADDR_W(16), .DATA_W(10), .BASE_ADDR(16'h0010),
                 .COUNT(1), .CLKS_PER_BIT(CPB))
    dut1 (.i_clk(clk), .i_ar(ar), .bus(bus1));

  ram_readback #(.ADDR_W(16), .DATA_W(10), .BASE_ADDR(16'hFFFF),
                 .COUNT(3), .CLKS_PER_BIT(CPB))
    dut3 (.i_clk(clk), .i_ar(ar), .bus(bus3));

  function automatic logic [9:0] mem1(input logic [15:0] a);
    return (a == 16'h0010) ? 10'h2B7 : 10'h000;
  endfunction

  function automatic logic [9:0] mem3(input logic [15:0] a);
    case (a)
      16'hFFFF: return 10'h3C1;
      16'h0000: return 10'h155;
      16'h0001: return 10'h2AA;
      default:  return 10'h3FF;
    endcase
  endfunction

  // synchronous RAMs with one cycle of read latency
  always @(posedge clk) begin
    if (bus1.o_ram_rden) bus1.i_ram_q <= mem1(bus1.o_ram_addr);
    if (bus3.o_ram_rden) bus3.i_ram_q <= mem3(bus3.o_ram_addr);
  end

  // reference 8N1 receivers; also flag any level change inside a bit
  logic       tx_line   [2];
  logic       rx_busy   [2] = '{1'b0, 1'b0};
  logic       rx_level  [2] = '{1'b1, 1'b1};
  logic [7:0] rx_shift  [2] = '{8'h00, 8'h00};
  int         rx_pos    [2] = '{0, 0};
  int         rx_glitch [2] = '{0, 0};
  int         rx_ferr   [2] = '{0, 0};
  int         rx_n      [2] = '{0, 0};
  int         done_cnt  [2] = '{0, 0};
  logic [7:0] rx_bytes  [2][32];

  assign tx_line[0] = bus1.o_tx;
  assign tx_line[1] = bus3.o_tx;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!ar) begin
        rx_busy[i] <= 1'b0;
      end else if (!rx_busy[i]) begin
        if (tx_line[i] === 1'b0) begin
          rx_busy[i]  <= 1'b1;
          rx_pos[i]   <= 1;
          rx_level[i] <= 1'b0;
        end
      end else begin
        if (rx_pos[i] % CPB == 0)
          rx_level[i] <= tx_line[i];
        else if (tx_line[i] !== rx_level[i])
          rx_glitch[i] <= rx_glitch[i] + 1;
        if (rx_pos[i] % CPB == CPB / 2) begin
          if (rx_pos[i] / CPB == 0) begin
            if (tx_line[i] !== 1'b0) rx_ferr[i] <= rx_ferr[i] + 1;
          end else if (rx_pos[i] / CPB == 9) begin
            if (tx_line[i] !== 1'b1) rx_ferr[i] <= rx_ferr[i] + 1;
          end else begin
            rx_shift[i] <= {tx_line[i], rx_shift[i][7:1]};
          end
        end
        if (rx_pos[i] == 10 * CPB - 1) begin
          rx_busy[i] <= 1'b0;
          if (rx_n[i] < 32) rx_bytes[i][rx_n[i]] <= rx_shift[i];
          rx_n[i] <= rx_n[i] + 1;
        end
        rx_pos[i] <= rx_pos[i] + 1;
      end
    end
  end

  // done pulse counters
  always @(negedge clk) begin
    if (bus1.o_done === 1'b1) done_cnt[0] <= done_cnt[0] + 1;
    if (bus3.o_done === 1'b1) done_cnt[1] <= done_cnt[1] + 1;
  end

  // read strobe monitor: 1-cycle pulses, line high in READ and LATCH, start bit next
  logic [15:0] rd_addr [16];
  int          rd_n = 0;
  int          rd_err = 0;
  int          gap_stage = 0;
  logic        rden_prev = 1'b0;

  always @(negedge clk) begin
    if (!ar) begin
      gap_stage <= 0;
      rden_prev <= 1'b0;
    end else begin
      rden_prev <= bus3.o_ram_rden;
      if (bus3.o_ram_rden === 1'b1) begin
        if (rden_prev || bus3.o_tx !== 1'b1) rd_err <= rd_err + 1;
        if (rd_n < 16) rd_addr[rd_n] <= bus3.o_ram_addr;
        rd_n      <= rd_n + 1;
        gap_stage <= 1;
      end else if (gap_stage == 1) begin
        if (bus3.o_tx !== 1'b1) rd_err <= rd_err + 1;
        gap_stage <= 2;
      end else if (gap_stage == 2) begin
        if (bus3.o_tx !== 1'b0) rd_err <= rd_err + 1;
        gap_stage <= 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 0) bus1.i_start = 1'b1; else bus3.i_start = 1'b1;
    @(negedge clk);
    bus1.i_start = 1'b0;
    bus3.i_start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (((which == 0) ? bus1.o_done : bus3.o_done) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  logic [7:0] exp1 [4] = '{8'hA5, 8'hB7, 8'h02, 8'hB5};
  logic [7:0] exp3 [8] = '{8'hA5, 8'hC1, 8'h03, 8'h55, 8'h01, 8'hAA, 8'h02, 8'h3E};
  logic [15:0] exp_addr [3] = '{16'hFFFF, 16'h0000, 16'h0001};

  // whole run must end on its own
  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, at, base, rd_base, done_before;

    // reset held with start asserted
    bus1.i_start = 1'b1;
    bus3.i_start = 1'b1;
    ar = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_tx1", bus1.o_tx, 1'b1);
      check("rst_busy1", bus1.o_busy, 1'b0);
      check("rst_rden1", bus1.o_ram_rden, 1'b0);
      check("rst_tx3", bus3.o_tx, 1'b1);
      check("rst_busy3", bus3.o_busy, 1'b0);
      check("rst_rden3", bus3.o_ram_rden, 1'b0);
    end
    check("rst_done1", bus1.o_done, 1'b0);
    check("rst_addr1", bus1.o_ram_addr, 16'h0010);
    check("rst_addr3", bus3.o_ram_addr, 16'hFFFF);
    bus1.i_start = 1'b0;
    bus3.i_start = 1'b0;
    ar = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy1", bus1.o_busy, 1'b0);
    check("idle_tx1", bus1.o_tx, 1'b1);
    check("idle_busy3", bus3.o_busy, 1'b0);

    // single word dump
    base = rx_n[0];
    pulse_start(0);
    check("w1_first_start_bit", bus1.o_tx, 1'b0);
    check("w1_busy", bus1.o_busy, 1'b1);
    s = cyc;
    wait_done(0, 400, at);
    check("w1_done_latency", at - s, 162);
    check("w1_busy_at_done", bus1.o_busy, 1'b1);
    @(negedge clk);
    check("w1_done_width", bus1.o_done, 1'b0);
    check("w1_busy_after", bus1.o_busy, 1'b0);
    repeat (5) @(negedge clk);
    check("w1_byte_count", rx_n[0] - base, 4);
    for (int i = 0; i < 4; i++) check($sformatf("w1_byte%0d", i), rx_bytes[0][base + i], exp1[i]);
    check("w1_glitches", rx_glitch[0], 0);
    check("w1_frame_errs", rx_ferr[0], 0);

    // three words wrapping past FFFF, with starts while busy
    base = rx_n[1];
    rd_base = rd_n;
    pulse_start(1);
    check("w3_first_start_bit", bus3.o_tx, 1'b0);
    s = cyc;
    repeat (100) @(negedge clk);
    bus3.i_start = 1'b1;
    @(negedge clk);
    bus3.i_start = 1'b0;
    check("w3_busy_mid", bus3.o_busy, 1'b1);
    wait_done(1, 1000, at);
    check("w3_done_latency", at - s, 326);
    bus3.i_start = 1'b1;
    @(negedge clk);
    bus3.i_start = 1'b0;
    check("w3_busy_after", bus3.o_busy, 1'b0);
    repeat (60) @(negedge clk);
    check("w3_no_restart", bus3.o_busy, 1'b0);
    check("w3_idle_tx", bus3.o_tx, 1'b1);
    check("w3_byte_count", rx_n[1] - base, 8);
    for (int i = 0; i < 8; i++) check($sformatf("w3_byte%0d", i), rx_bytes[1][base + i], exp3[i]);
    check("w3_read_count", rd_n - rd_base, 3);
    for (int i = 0; i < 3; i++) check($sformatf("w3_addr%0d", i), rd_addr[rd_base + i], exp_addr[i]);
    check("w3_rden_gap_errs", rd_err, 0);
    check("w3_glitches", rx_glitch[1], 0);
    check("w3_frame_errs", rx_ferr[1], 0);

    // reset during data bit 4 of the second data byte (0x03)
    base = rx_n[1];
    done_before = done_cnt[1];
    pulse_start(1);
    s = cyc;
    repeat (103) @(negedge clk);
    check("mid_bit4_level", bus3.o_tx, 1'b0);
    #1 ar = 1'b0;
    #1;
    check("mid_rst_tx", bus3.o_tx, 1'b1);
    check("mid_rst_busy", bus3.o_busy, 1'b0);
    check("mid_rst_rden", bus3.o_ram_rden, 1'b0);
    repeat (3) @(negedge clk);
    ar = 1'b1;
    repeat (60) @(negedge clk);
    check("mid_no_done", done_cnt[1] - done_before, 0);
    check("mid_idle_busy", bus3.o_busy, 1'b0);
    check("mid_partial_bytes", rx_n[1] - base, 2);

    // fresh dump after the aborted one
    base = rx_n[1];
    rd_base = rd_n;
    pulse_start(1);
    s = cyc;
    wait_done(1, 1000, at);
    check("re_done_latency", at - s, 326);
    repeat (5) @(negedge clk);
    check("re_byte_count", rx_n[1] - base, 8);
    for (int i = 0; i < 8; i++) check($sformatf("re_byte%0d", i), rx_bytes[1][base + i], exp3[i]);
    check("re_read_count", rd_n - rd_base, 3);
    for (int i = 0; i < 3; i++) check($sformatf("re_addr%0d", i), rd_addr[rd_base + i], exp_addr[i]);
    check("re_rden_gap_errs", rd_err, 0);
    check("re_glitches", rx_glitch[1], 0);
    check("re_frame_errs", rx_ferr[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_readback.md
# ram_readback

Sequential dump engine for the simulation state RAM: on a start pulse it reads a fixed address window word by word and streams the contents out of the board over a UART transmit line, framed by a header byte and an XOR checksum. It is the read-side counterpart of the switch-driven RAM write path in the top level. It shares the RAM's clock, so the host can capture redstone component state without a debugger.

## Interface
Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 10, RAM word width; legal range 1..32.
- BASE_ADDR, 16'hFC00, first address dumped.
- COUNT, 1024, number of words dumped; legal range 1..2^ADDR_W.
- CLKS_PER_BIT, 434, clock cycles per UART bit; minimum 2.

Ports:
- i_clk  in  1  Sole clock; also clocks the RAM.
- i_ar  in  1  Reset; asynchronous, active-low.
- i_start  in  1  Single-cycle request to begin a dump.
- i_ram_q  in  DATA_W  RAM read data; valid exactly 1 cycle after o_ram_rden.
- o_ram_addr  out  ADDR_W  RAM read address.
- o_ram_rden  out  1  RAM read strobe; 1-cycle pulse.
- o_tx  out  1  UART line: 8N1, LSB first, idles high.
- o_busy  out  1  High from the cycle after an accepted start through the DONE cycle.
- o_done  out  1  1-cycle pulse when the checksum stop bit completes.

## Operation
- Bytes per word: NB = ceil(DATA_W/8). Each word is sent little-endian, and the unused upper bits of the top byte are 0.
- Stream order: 0xA5 header, then COUNT words × NB bytes, then checksum. The checksum is the XOR of all data bytes and excludes the header.
- Address of word k = (BASE_ADDR + k) mod 2^ADDR_W. Wrap past all-ones is legal.
- FSM states:
  - IDLE: o_tx=1, o_busy=0. Goes to HDR on i_start.
  - HDR: transmits 0xA5, then goes to READ.
  - READ: 1 cycle. Drives o_ram_addr and pulses o_ram_rden. Goes to LATCH.
  - LATCH: 1 cycle. Captures i_ram_q into a word buffer and clears the byte index. Goes to DATA.
  - DATA: transmits NB bytes from the buffer. Returns to READ if words remain, otherwise goes to SUM.
  - SUM: transmits the checksum, then goes to DONE.
  - DONE: 1 cycle. Pulses o_done, then returns to IDLE.
- Byte transmitter is an internal sub-FSM:
  - Start bit (0), 8 data bits, stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - A per-bit cycle counter and a bit index are reset at every byte load.
- Checksum register clears on HDR entry and XORs in each data byte when that byte is loaded into the transmitter.
- i_start is ignored outside IDLE, including in the DONE cycle.
- o_ram_addr holds its last value outside READ. o_ram_rden is 0 outside READ.

## Timing
- Reset values, applied asynchronously while i_ar=0:
  - o_tx=1, o_busy=0, o_done=0, o_ram_rden=0, o_ram_addr=BASE_ADDR.
  - FSM=IDLE, checksum=0, all counters=0.
- Reset mid-dump: the line returns high immediately. No partial byte completes and no o_done is produced. The next start begins a fresh dump.
- If i_start is sampled high at edge N:
  - o_busy=1 and o_tx=0 (header start bit) from edge N+1.
- Each byte occupies 10×CLKS_PER_BIT cycles.
- Consecutive bytes within a word and across header/sum are back-to-back, with no idle bits.
- Each word adds a 2-cycle gap (READ + LATCH) between the preceding stop bit and its first start bit. During the gap o_tx=1.
- Total dump length from the first start bit to the o_done cycle = (COUNT×NB + 2)×10×CLKS_PER_BIT + 2×COUNT cycles. The o_done pulse occupies the cycle after the last stop bit ends; o_busy drops with it.
- i_ram_q is sampled only in LATCH, so any RAM output register beyond 1 cycle is out of scope.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_W=10, ADDR_W=16.
- Reset check: hold i_ar=0 while i_start=1 → o_tx=1, o_busy=0, o_ram_rden=0 throughout. Release reset → stays idle until the next start.
- Single word: COUNT=1, BASE_ADDR=16'h0010, mem[0x10]=10'h2B7.
  - Decoded bytes A5, B7, 02, B5.
  - First start bit 1 cycle after i_start; o_done exactly 162 cycles after the first start bit.
- Multi-word with wrap: COUNT=3, BASE_ADDR=16'hFFFF.
  - Read addresses FFFF, 0000, 0001 in order.
  - Each o_ram_rden pulse is 1 cycle and is followed by a 1-cycle o_tx-high gap before the start bit.
  - Checksum equals the XOR of the 6 data bytes.
- Start while busy: pulse i_start mid-stream and again in the DONE cycle → byte stream unchanged and no second header.
- Reset mid-byte: assert i_ar during bit 4 of the second data byte → o_tx=1 at once and no o_done. A new start then yields a complete, correct dump.
- Bit timing: every bit on o_tx is held exactly 4 cycles, the stop bit is 1, and bits arrive LSB first. The bench checks this with a reference 8N1 receiver model sampling at mid-bit.
